fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with stall hold register and redirect
//
// Purpose: issues instruction-memory reads, presents (pcF, instrF) to decode,
// holds the current instruction while decode stalls, and redirects on branch/jump.
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   stallD            decode will not accept a new instruction this cycle
//   pc_selD, tgt_pcD  PC source select (01 branch, 10 jump) and redirect target
//   imem_dout         instruction memory read data, one cycle after the request
//   imem_addr, imem_en instruction memory request
//   pcF, instrF       instruction (and its address) presented to decode

`ifndef XLEN
`define XLEN 32
`endif

module fetch_unit #(
  parameter logic [`XLEN-1:0] RESET_PC  = 32'h0000_2000,
  parameter logic [`XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallD,
  input  logic [1:0]       pc_selD,
  input  logic [`XLEN-1:0] tgt_pcD,
  input  logic [`XLEN-1:0] imem_dout,
  output logic [`XLEN-1:0] imem_addr,
  output logic             imem_en,
  output logic [`XLEN-1:0] pcF,
  output logic [`XLEN-1:0] instrF
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [`XLEN-1:0] pc_q, pc_d;
  logic [`XLEN-1:0] hold_q, hold_d;

  logic             redirect;
  logic             advance;
  logic [`XLEN-1:0] next_pc;

  // pc_selD = 11 is reserved and falls through to sequential.
  assign redirect = (pc_selD == 2'b01) || (pc_selD == 2'b10);
  // A redirect also flushes whatever decode is stalling on.
  assign advance  = redirect || !stallD;
  // Target is word-aligned; the sequential add wraps naturally at 2^XLEN.
  assign next_pc  = redirect ? {tgt_pcD[`XLEN-1:2], 2'b00} : pc_q + `XLEN'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    imem_en   = 1'b0;
    imem_addr = next_pc;
    pcF       = pc_q;
    instrF    = NOP_INSTR;

    case (state_q)
      BOOT: begin
        imem_en   = 1'b1;
        imem_addr = RESET_PC;
        pcF       = RESET_PC;
        pc_d      = RESET_PC;
        state_d   = RUN;
      end
      RUN: begin
        instrF = imem_dout;
        if (advance) begin
          imem_en = 1'b1;
          pc_d    = next_pc;
        end else begin
          // Memory output is only valid for one cycle; capture it for the stall.
          hold_d  = imem_dout;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instrF = hold_q;
        if (advance) begin
          imem_en = 1'b1;
          pc_d    = next_pc;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (rst) begin
      imem_en = 1'b0;
      instrF  = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

endmodule
